margin_checker: RTL and testbench
=================================

MARGIN_CHECKER -- requirements
Module: margin_checker

Interface
REQ-001 The block SHALL have parameter MATRIX_ROW, default 2, number of matrix rows (>=1).
REQ-002 The block SHALL have parameter MATRIX_COL, default 2, number of matrix columns (>=1).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-005 The block SHALL have port start, input, 1, starts a scan; sampled only in IDLE.
REQ-006 The block SHALL have port mode, input, 1, sampled with start: 0 = CAPTURE reference margins, 1 = CHECK against them.
REQ-007 The block SHALL have port m, input, logic array [MATRIX_ROW][MATRIX_COL], the binary matrix under test.
REQ-008 The block SHALL have port busy, output, 1, high in SCAN and DONE.
REQ-009 The block SHALL have port done, output, 1, one-cycle pulse at scan completion.
REQ-010 The block SHALL have port pass, output, 1, result of the last completed scan; held until the next completion.
REQ-011 The block SHALL have port ref_valid, output, 1, high once a CAPTURE has completed.

Function
REQ-012 Sum width SHALL be $clog2(N+1) bits (N = MATRIX_COL for row sums, MATRIX_ROW for column sums); sums SHALL NOT overflow or wrap.
REQ-013 FSM states SHALL be IDLE, SCAN, DONE; IDLE->SCAN on start=1; SCAN->DONE after row MATRIX_ROW-1; DONE->IDLE unconditionally after one cycle.
REQ-014 On the accepting cycle T the block SHALL snapshot m and mode; later changes to m SHALL NOT affect the scan.
REQ-015 In SCAN the block SHALL process one snapshot row per cycle, row r at cycle T+1+r: popcount to row sum, add each bit to its column accumulator.
REQ-016 Column accumulators SHALL be cleared on the accepting cycle.
REQ-017 done SHALL assert exactly at cycle T+MATRIX_ROW+1; busy SHALL be high from T+1 through T+MATRIX_ROW+1.
REQ-018 CAPTURE: the block SHALL store all row and column sums as reference, set ref_valid at done, and set pass=1.
REQ-019 CHECK: pass SHALL be 1 only if ref_valid=1 and every row and column sum equals its reference; otherwise 0.
REQ-020 CHECK with ref_valid=0 SHALL still run the full scan and return pass=0 at the normal done cycle.
REQ-021 CHECK SHALL NOT modify stored reference or ref_valid.
REQ-022 start asserted while busy=1 SHALL be ignored, not queued.
REQ-023 start held high continuously SHALL start a new scan in each IDLE cycle, i.e. back-to-back scans separated by one IDLE cycle.

Reset
REQ-024 With rst_n=0 at a clock edge: state=IDLE, busy=0, done=0, pass=0, ref_valid=0, accumulators and reference sums cleared.
REQ-025 Reset during SCAN or DONE SHALL abort the scan with no done pulse and no change to stored reference beyond the clearing of REQ-024.

Configuration
REQ-026 Macro MARGIN_ERR_IDX_EN SHALL, when defined, add outputs err_vld (1 bit) and err_row ($clog2(MATRIX_ROW) bits, min 1).
REQ-027 With MARGIN_ERR_IDX_EN defined, at done of a CHECK, err_vld SHALL be 1 if any row sum mismatched and err_row SHALL be the lowest mismatching row index; both held until next done; both 0 after reset and after CAPTURE.
REQ-028 Without MARGIN_ERR_IDX_EN the ports and their logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 2x2, reset release, CAPTURE m=[[1,0],[0,1]] start at T -> done only at T+3, pass=1, ref_valid=1.
REQ-030 After REQ-029, CHECK m=[[0,1],[1,0]] (checkerboard swap) -> pass=1; then CHECK [[1,1],[0,1]] -> pass=0, err_vld=1, err_row=0 (macro on).
REQ-031 CHECK [[1,0],[1,0]] after REQ-029 (row sums match, column sums 2/0 vs 1/1) -> pass=0, err_vld=0.
REQ-032 From reset, CHECK any m -> done at T+3, pass=0, ref_valid=0.
REQ-033 During SCAN of a CHECK, change m to all-ones and pulse start -> result reflects snapshot only; start ignored; exactly one done.
REQ-034 rst_n=0 at T+1 of a CAPTURE -> no done pulse, ref_valid=0, busy=0 at next cycle.

Source files
------------

// File: rtl/margin_checker.sv
// Scans a binary matrix one row per cycle, captures row/column popcounts as a
// reference or checks them against it. Define MARGIN_ERR_IDX_EN for err_vld/err_row.
module margin_checker #(
   parameter int MATRIX_ROW = 2,
   parameter int MATRIX_COL = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic mode,
   input  logic m [MATRIX_ROW][MATRIX_COL],
   output logic busy,
   output logic done,
   output logic pass,
`ifdef MARGIN_ERR_IDX_EN
   output logic err_vld,
   output logic [((MATRIX_ROW > 1) ? $clog2(MATRIX_ROW) : 1)-1:0] err_row,
`endif
   output logic ref_valid
);
   localparam int RSW = $clog2(MATRIX_COL + 1);
   localparam int CSW = $clog2(MATRIX_ROW + 1);
   localparam int RIW = (MATRIX_ROW > 1) ? $clog2(MATRIX_ROW) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t         state_q, state_d;
   logic [RIW-1:0] row_q, row_d;
   logic           mode_q, mode_d;
   logic           snap_q [MATRIX_ROW][MATRIX_COL];
   logic           snap_d [MATRIX_ROW][MATRIX_COL];
   logic [CSW-1:0] col_acc_q [MATRIX_COL];
   logic [CSW-1:0] col_acc_d [MATRIX_COL];
   logic [RSW-1:0] ref_row_q [MATRIX_ROW];
   logic [RSW-1:0] ref_row_d [MATRIX_ROW];
   logic [CSW-1:0] ref_col_q [MATRIX_COL];
   logic [CSW-1:0] ref_col_d [MATRIX_COL];
   logic           ref_valid_q, ref_valid_d;
   logic           pass_q, pass_d;
   logic           row_mis_q, row_mis_d;
`ifdef MARGIN_ERR_IDX_EN
   logic [RIW-1:0] mis_row_q, mis_row_d;
   logic           err_vld_q, err_vld_d;
   logic [RIW-1:0] err_row_q, err_row_d;
`endif

   logic [RSW-1:0] row_sum;
   logic [CSW-1:0] col_next [MATRIX_COL];
   logic           col_match;
   logic           last_row;
   logic           row_mis_now;

   // Per-row arithmetic on the snapshot row currently addressed by row_q
   always_comb begin
      row_sum   = '0;
      col_match = 1'b1;
      for (int c = 0; c < MATRIX_COL; c++) begin
         row_sum     = row_sum + RSW'(snap_q[row_q][c]);
         col_next[c] = col_acc_q[c] + CSW'(snap_q[row_q][c]);
         if (col_next[c] != ref_col_q[c]) col_match = 1'b0;
      end
      last_row    = (row_q == RIW'(MATRIX_ROW - 1));
      row_mis_now = (row_sum != ref_row_q[row_q]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = SCAN;
         SCAN:    if (last_row) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      pass      = pass_q;
      ref_valid = ref_valid_q;
`ifdef MARGIN_ERR_IDX_EN
      err_vld   = err_vld_q;
      err_row   = err_row_q;
`endif
   end

   always_comb begin
      row_d       = row_q;
      mode_d      = mode_q;
      snap_d      = snap_q;
      col_acc_d   = col_acc_q;
      ref_row_d   = ref_row_q;
      ref_col_d   = ref_col_q;
      ref_valid_d = ref_valid_q;
      pass_d      = pass_q;
      row_mis_d   = row_mis_q;
`ifdef MARGIN_ERR_IDX_EN
      mis_row_d   = mis_row_q;
      err_vld_d   = err_vld_q;
      err_row_d   = err_row_q;
`endif
      if (state_q == IDLE && start) begin
         snap_d    = m;
         mode_d    = mode;
         row_d     = '0;
         row_mis_d = 1'b0;
         for (int c = 0; c < MATRIX_COL; c++) col_acc_d[c] = '0;
`ifdef MARGIN_ERR_IDX_EN
         mis_row_d = '0;
`endif
      end else if (state_q == SCAN) begin
         row_d     = last_row ? '0 : row_q + 1'b1;
         col_acc_d = col_next;
         if (!mode_q) begin
            ref_row_d[row_q] = row_sum;
         end else if (row_mis_now && !row_mis_q) begin
            row_mis_d = 1'b1;
`ifdef MARGIN_ERR_IDX_EN
            mis_row_d = row_q;
`endif
         end
         // Results land on the edge that enters DONE so they are visible with done
         if (last_row) begin
            if (!mode_q) begin
               ref_col_d   = col_next;
               ref_valid_d = 1'b1;
               pass_d      = 1'b1;
`ifdef MARGIN_ERR_IDX_EN
               err_vld_d   = 1'b0;
               err_row_d   = '0;
`endif
            end else begin
               pass_d    = ref_valid_q && !(row_mis_q || row_mis_now) && col_match;
`ifdef MARGIN_ERR_IDX_EN
               err_vld_d = row_mis_q || row_mis_now;
               err_row_d = row_mis_q ? mis_row_q : (row_mis_now ? row_q : '0);
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row_q       <= '0;
         mode_q      <= 1'b0;
         ref_valid_q <= 1'b0;
         pass_q      <= 1'b0;
         row_mis_q   <= 1'b0;
         for (int r = 0; r < MATRIX_ROW; r++) begin
            ref_row_q[r] <= '0;
            for (int c = 0; c < MATRIX_COL; c++) snap_q[r][c] <= 1'b0;
         end
         for (int c = 0; c < MATRIX_COL; c++) begin
            col_acc_q[c] <= '0;
            ref_col_q[c] <= '0;
         end
`ifdef MARGIN_ERR_IDX_EN
         mis_row_q   <= '0;
         err_vld_q   <= 1'b0;
         err_row_q   <= '0;
`endif
      end else begin
         row_q       <= row_d;
         mode_q      <= mode_d;
         snap_q      <= snap_d;
         col_acc_q   <= col_acc_d;
         ref_row_q   <= ref_row_d;
         ref_col_q   <= ref_col_d;
         ref_valid_q <= ref_valid_d;
         pass_q      <= pass_d;
         row_mis_q   <= row_mis_d;
`ifdef MARGIN_ERR_IDX_EN
         mis_row_q   <= mis_row_d;
         err_vld_q   <= err_vld_d;
         err_row_q   <= err_row_d;
`endif
      end
   end
endmodule

// File: tb/tb_margin_checker.sv
// Directed bench for margin_checker (2x2); err_vld/err_row checks follow MARGIN_ERR_IDX_EN.
module tb_margin_checker;
   logic clk = 1'b0;
   logic rst_n, start, mode;
   logic m [2][2];
   logic busy, done, pass, ref_valid;
`ifdef MARGIN_ERR_IDX_EN
   logic       err_vld;
   logic [0:0] err_row;
`endif
   int errors = 0;
   int checks = 0;
   int fd, nd;

   always #5 clk = ~clk;

   margin_checker #(.MATRIX_ROW(2), .MATRIX_COL(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .mode      (mode),
      .m         (m),
      .busy      (busy),
      .done      (done),
      .pass      (pass),
`ifdef MARGIN_ERR_IDX_EN
      .err_vld   (err_vld),
      .err_row   (err_row),
`endif
      .ref_valid (ref_valid)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // bits = {m[0][0], m[0][1], m[1][0], m[1][1]}
   task automatic set_m(input logic [3:0] b);
      m[0][0] = b[3]; m[0][1] = b[2]; m[1][0] = b[1]; m[1][1] = b[0];
   endtask

   // Accept on edge T, then watch 6 edges; first_done counts edges after T.
   task automatic run_scan(input logic md, input logic [3:0] b, input bit disturb,
                           output int first_done, output int n_done);
      first_done = -1;
      n_done     = 0;
      set_m(b);
      mode  = md;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("busy_after_accept", busy, 1'b1);
      for (int k = 1; k <= 6; k++) begin
         if (k == 1 && disturb) begin
            set_m(4'b1111);
            mode  = 1'b0;
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         if (done) begin
            n_done++;
            if (first_done < 0) first_done = k;
         end
      end
      $display("scan mode=%0d m=%b disturb=%0d done_at=T+%0d dones=%0d pass=%0d ref_valid=%0d",
               md, b, disturb, first_done + 1, n_done, pass, ref_valid);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; mode = 1'b0;
      set_m(4'b0000);
      tick(); tick();
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_pass", pass, 1'b0);
      chk("rst_ref_valid", ref_valid, 1'b0);
`ifdef MARGIN_ERR_IDX_EN
      chk("rst_err_vld", err_vld, 1'b0);
`endif
      rst_n = 1'b1;
      tick();

      // CHECK with no reference: full scan, pass=0
      run_scan(1'b1, 4'b1101, 1'b0, fd, nd);
      chk("noref_latency", fd, 2);
      chk("noref_ndone", nd, 1);
      chk("noref_pass", pass, 1'b0);
      chk("noref_ref_valid", ref_valid, 1'b0);

      // Cycle-exact done/busy on a CAPTURE, then abort it with reset at T+1
      set_m(4'b1001); mode = 1'b0; start = 1'b1;
      tick();
      start = 1'b0;
      rst_n = 1'b0;
      tick();
      chk("abort_busy", busy, 1'b0);
      chk("abort_done", done, 1'b0);
      chk("abort_ref_valid", ref_valid, 1'b0);
      rst_n = 1'b1;
      nd = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done) nd++;
      end
      chk("abort_no_done", nd, 0);
      $display("abort capture at T+1 dones=%0d ref_valid=%0d", nd, ref_valid);

      // CAPTURE [[1,0],[0,1]]
      run_scan(1'b0, 4'b1001, 1'b0, fd, nd);
      chk("cap_latency", fd, 2);
      chk("cap_ndone", nd, 1);
      chk("cap_pass", pass, 1'b1);
      chk("cap_ref_valid", ref_valid, 1'b1);
      chk("cap_idle_busy", busy, 1'b0);

      run_scan(1'b1, 4'b0110, 1'b0, fd, nd);
      chk("swap_pass", pass, 1'b1);
`ifdef MARGIN_ERR_IDX_EN
      chk("swap_err_vld", err_vld, 1'b0);
`endif

      run_scan(1'b1, 4'b1101, 1'b0, fd, nd);
      chk("row0_pass", pass, 1'b0);
`ifdef MARGIN_ERR_IDX_EN
      chk("row0_err_vld", err_vld, 1'b1);
      chk("row0_err_row", err_row, 1'b0);
`endif

      run_scan(1'b1, 4'b1010, 1'b0, fd, nd);
      chk("colonly_pass", pass, 1'b0);
`ifdef MARGIN_ERR_IDX_EN
      chk("colonly_err_vld", err_vld, 1'b0);
`endif

      run_scan(1'b1, 4'b1011, 1'b0, fd, nd);
      chk("row1_pass", pass, 1'b0);
`ifdef MARGIN_ERR_IDX_EN
      chk("row1_err_vld", err_vld, 1'b1);
      chk("row1_err_row", err_row, 1'b1);
`endif

      run_scan(1'b1, 4'b0000, 1'b0, fd, nd);
      chk("both_pass", pass, 1'b0);
`ifdef MARGIN_ERR_IDX_EN
      chk("both_err_row", err_row, 1'b0);
`endif

      // Snapshot isolation and ignored start during SCAN
      run_scan(1'b1, 4'b0110, 1'b1, fd, nd);
      chk("snap_latency", fd, 2);
      chk("snap_ndone", nd, 1);
      chk("snap_pass", pass, 1'b1);
      chk("snap_ref_valid", ref_valid, 1'b1);

      // New reference: all ones
      run_scan(1'b0, 4'b1111, 1'b0, fd, nd);
      chk("cap2_pass", pass, 1'b1);
`ifdef MARGIN_ERR_IDX_EN
      chk("cap2_err_vld", err_vld, 1'b0);
`endif
      run_scan(1'b1, 4'b1001, 1'b0, fd, nd);
      chk("cap2_check_diag", pass, 1'b0);

      // start held high: back-to-back scans with one IDLE cycle in between
      set_m(4'b1111); mode = 1'b1; start = 1'b1;
      fd = -1; nd = 0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (done) begin
            nd++;
            if (nd == 2) fd = k;
         end
      end
      start = 1'b0;
      chk("b2b_ndone", nd, 2);
      chk("b2b_second_done", fd, 7);
      chk("b2b_pass", pass, 1'b1);
      $display("back-to-back dones=%0d second_done_edge=%0d pass=%0d", nd, fd, pass);
      for (int k = 0; k < 4; k++) tick();
      chk("b2b_idle", busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
